// File: rtl/pipe_pkg.sv
// Shared pipeline types: occupancy encoding and per-stage control bundles.
package pipe_pkg;

    typedef enum logic [1:0] {
        OCC_EMPTY = 2'd0,
        OCC_ONE   = 2'd1,
        OCC_FULL  = 2'd2
    } occ_e;

    typedef struct packed {
        logic reg_write;
        logic mem_to_reg;
        logic mem_write;
        logic mem_read;
        logic branch;
        logic zero;
    } ex_mem_ctrl_t;

    typedef struct packed {
        logic reg_write;
        logic mem_to_reg;
    } mem_wb_ctrl_t;

    localparam int EX_MEM_CTRL_W = $bits(ex_mem_ctrl_t);
    localparam int MEM_WB_CTRL_W = $bits(mem_wb_ctrl_t);
    // pc + ALU result + write data + write reg number
    localparam int EX_MEM_DATA_W = 32 + 32 + 32 + 5;

endpackage

// File: rtl/pipe_slot.sv
// One pipeline entry: valid + control + payload register with load and clear.
module pipe_slot #(
    parameter int CTRL_W = 6,
    parameter int DATA_W = 101
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr_i,
    input  logic              ld_i,
    input  logic [CTRL_W-1:0] ctrl_i,
    input  logic [DATA_W-1:0] data_i,
    output logic              valid_o,
    output logic [CTRL_W-1:0] ctrl_o,
    output logic [DATA_W-1:0] data_o
);

    logic              valid_q;
    logic [CTRL_W-1:0] ctrl_q;
    logic [DATA_W-1:0] data_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            ctrl_q  <= '0;
            data_q  <= '0;
        end else if (clr_i) begin
            valid_q <= 1'b0;
            ctrl_q  <= '0;
        end else if (ld_i) begin
            valid_q <= 1'b1;
            ctrl_q  <= ctrl_i;
            data_q  <= data_i;
        end
    end

    assign valid_o = valid_q;
    assign ctrl_o  = ctrl_q;
    assign data_o  = data_q;

endmodule

// File: rtl/pipe_stage_elastic.sv
// Elastic pipeline stage: 2-entry skid buffer, registered in_ready, sync flush.
// Optional perf counters (stall_cnt, bubble_cnt) under PIPE_STAGE_PERF_EN.
module pipe_stage_elastic
    import pipe_pkg::*;
#(
    parameter int CTRL_W = EX_MEM_CTRL_W,
    parameter int DATA_W = EX_MEM_DATA_W,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
`ifdef PIPE_STAGE_PERF_EN
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  bubble_cnt,
`endif
    output logic [1:0]        occupancy
);

    occ_e occ_q, occ_d;

    logic              main_ld, main_clr, main_from_skid;
    logic              skid_ld, skid_clr;
    logic              main_valid, skid_valid;
    logic [CTRL_W-1:0] main_ctrl, skid_ctrl, main_ctrl_in;
    logic [DATA_W-1:0] main_data, skid_data, main_data_in;
    logic              in_fire, out_fire;

    assign in_ready = ~skid_valid & ~rst;
    assign in_fire  = in_valid & in_ready;
    assign out_fire = out_valid & out_ready;

    always_comb begin
        occ_d          = occ_q;
        main_ld        = 1'b0;
        main_clr       = 1'b0;
        main_from_skid = 1'b0;
        skid_ld        = 1'b0;
        skid_clr       = 1'b0;
        if (flush) begin
            occ_d    = OCC_EMPTY;
            main_clr = 1'b1;
            skid_clr = 1'b1;
        end else begin
            unique case (occ_q)
                OCC_EMPTY: begin
                    if (in_fire) begin
                        occ_d   = OCC_ONE;
                        main_ld = 1'b1;
                    end
                end
                OCC_ONE: begin
                    if (in_fire && out_fire) begin
                        main_ld = 1'b1;
                    end else if (in_fire) begin
                        occ_d   = OCC_FULL;
                        skid_ld = 1'b1;
                    end else if (out_fire) begin
                        occ_d    = OCC_EMPTY;
                        main_clr = 1'b1;
                    end
                end
                OCC_FULL: begin
                    if (out_fire) begin
                        occ_d          = OCC_ONE;
                        main_ld        = 1'b1;
                        main_from_skid = 1'b1;
                        skid_clr       = 1'b1;
                    end
                end
                default: begin
                    occ_d    = OCC_EMPTY;
                    main_clr = 1'b1;
                    skid_clr = 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) occ_q <= OCC_EMPTY;
        else     occ_q <= occ_d;
    end

    assign main_ctrl_in = main_from_skid ? skid_ctrl : in_ctrl;
    assign main_data_in = main_from_skid ? skid_data : in_data;

    pipe_slot #(.CTRL_W(CTRL_W), .DATA_W(DATA_W)) u_main (
        .clk     (clk),
        .rst     (rst),
        .clr_i   (main_clr),
        .ld_i    (main_ld),
        .ctrl_i  (main_ctrl_in),
        .data_i  (main_data_in),
        .valid_o (main_valid),
        .ctrl_o  (main_ctrl),
        .data_o  (main_data)
    );

    pipe_slot #(.CTRL_W(CTRL_W), .DATA_W(DATA_W)) u_skid (
        .clk     (clk),
        .rst     (rst),
        .clr_i   (skid_clr),
        .ld_i    (skid_ld),
        .ctrl_i  (in_ctrl),
        .data_i  (in_data),
        .valid_o (skid_valid),
        .ctrl_o  (skid_ctrl),
        .data_o  (skid_data)
    );

    // A bubble never carries control bits, whatever the slot still holds.
    assign out_valid = main_valid;
    assign out_ctrl  = main_valid ? main_ctrl : '0;
    assign out_data  = main_data;
    assign occupancy = occ_q;

`ifdef PIPE_STAGE_PERF_EN
    logic [CNT_W-1:0] stall_q, bubble_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_q  <= '0;
            bubble_q <= '0;
        end else begin
            if (out_valid && !out_ready && !(&stall_q))
                stall_q <= stall_q + CNT_W'(1);
            if (!out_valid && !(&bubble_q))
                bubble_q <= bubble_q + CNT_W'(1);
        end
    end

    assign stall_cnt  = stall_q;
    assign bubble_cnt = bubble_q;
`endif

endmodule

// File: tb/tb_pipe_stage_elastic.sv
// Bench for pipe_stage_elastic: directed scenarios plus random traffic
// checked every cycle against a queue-based reference model.
module tb_pipe_stage_elastic;

    localparam int CW = 6;
    localparam int DW = 32;
    localparam int NW = 4;

    logic          clk = 1'b0;
    logic          rst, flush, in_valid, out_ready;
    logic          in_ready, out_valid;
    logic [CW-1:0] in_ctrl, out_ctrl;
    logic [DW-1:0] in_data, out_data;
    logic [1:0]    occupancy;
`ifdef PIPE_STAGE_PERF_EN
    logic [NW-1:0] stall_cnt, bubble_cnt;
`endif

    pipe_stage_elastic #(.CTRL_W(CW), .DATA_W(DW), .CNT_W(NW)) dut (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_ctrl    (in_ctrl),
        .in_data    (in_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_ctrl   (out_ctrl),
        .out_data   (out_data),
`ifdef PIPE_STAGE_PERF_EN
        .stall_cnt  (stall_cnt),
        .bubble_cnt (bubble_cnt),
`endif
        .occupancy  (occupancy)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    // Reference: a FIFO of at most two entries, head visible on the outputs.
    logic [CW+DW-1:0] q[$];
    int stall_m  = 0;
    int bubble_m = 0;
    int sat_max  = (1 << NW) - 1;

    task automatic check(input string name, input logic [63:0] got,
                         input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp,
                     $time);
        end
    endtask

    always @(posedge clk) begin
        bit inf, outf;
        inf  = in_valid && !rst && q.size() < 2;
        outf = q.size() > 0 && out_ready;
        if (rst) begin
            stall_m  = 0;
            bubble_m = 0;
        end else begin
            if (q.size() > 0 && !out_ready && stall_m < sat_max) stall_m++;
            if (q.size() == 0 && bubble_m < sat_max) bubble_m++;
        end
        if (rst || flush) begin
            q.delete();
        end else begin
            if (outf) void'(q.pop_front());
            if (inf) q.push_back({in_ctrl, in_data});
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            logic [CW+DW-1:0] h;
            h = (q.size() > 0) ? q[0] : '0;
            check("m_valid", out_valid, q.size() > 0);
            check("m_ready", in_ready, !rst && q.size() < 2);
            check("m_occ", occupancy, q.size());
            check("m_ctrl", out_ctrl, h[CW+DW-1:DW]);
            if (q.size() > 0) check("m_data", out_data, h[DW-1:0]);
`ifdef PIPE_STAGE_PERF_EN
            check("m_stall", stall_cnt, stall_m);
            check("m_bubble", bubble_cnt, bubble_m);
`endif
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic put(input logic v, input logic [CW-1:0] c,
                       input logic [DW-1:0] d);
        in_valid = v;
        in_ctrl  = c;
        in_data  = d;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    initial begin
        logic [DW-1:0] seq [5];
        seq = '{32'hA, 32'hB, 32'hC, 32'hD, 32'hE};
        rst = 1'b1; flush = 1'b0; out_ready = 1'b1;
        put(1'b1, 6'h15, 32'h1111);

        // 1: reset held 3 cycles with in_valid high
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_en = 1'b1;
            check("rst_valid", out_valid, 1'b0);
            check("rst_ctrl", out_ctrl, 6'h0);
            check("rst_occ", occupancy, 2'd0);
            check("rst_ready", in_ready, 1'b0);
        end
        rst = 1'b0;
        put(1'b0, 6'h0, 32'h0);
        tick();

        // 2: stream A..E at full rate
        for (int i = 0; i < 5; i++) begin
            put(1'b1, CW'(i + 1), seq[i]);
            tick();
            check("strm_valid", out_valid, 1'b1);
            check("strm_data", out_data, seq[i]);
        end
        put(1'b0, 6'h0, 32'h0);
        tick();
        check("strm_drain", out_valid, 1'b0);

        // 3: backpressure fills the skid, then drains in order
        out_ready = 1'b0;
        put(1'b1, 6'h01, 32'hA);
        tick();
        put(1'b1, 6'h02, 32'hB);
        tick();
        put(1'b0, 6'h0, 32'h0);
        check("bp_occ", occupancy, 2'd2);
        check("bp_ready", in_ready, 1'b0);
        check("bp_hold0", out_data, 32'hA);
        tick();
        check("bp_hold1", out_data, 32'hA);
        out_ready = 1'b1;
        #1 check("bp_first", out_data, 32'hA);
        tick();
        check("bp_second", out_data, 32'hB);
        tick();
        check("bp_empty", out_valid, 1'b0);

        // 4: flush in FULL with a concurrent input beat
        out_ready = 1'b0;
        put(1'b1, 6'h01, 32'hA);
        tick();
        put(1'b1, 6'h02, 32'hB);
        tick();
        put(1'b1, 6'h03, 32'hC);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        put(1'b0, 6'h0, 32'h0);
        check("fl_valid", out_valid, 1'b0);
        check("fl_ctrl", out_ctrl, 6'h0);
        check("fl_occ", occupancy, 2'd0);
        out_ready = 1'b1;
        tick();
        check("fl_noC", out_valid, 1'b0);

        // 5: all control bits set, then flushed away
        out_ready = 1'b0;
        put(1'b1, 6'h3F, 32'hDEAD_BEEF);
        tick();
        put(1'b0, 6'h0, 32'h0);
        check("k_ctrl", out_ctrl, 6'h3F);
        check("k_data", out_data, 32'hDEAD_BEEF);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("k_bub_v", out_valid, 1'b0);
        check("k_bub_c", out_ctrl, 6'h0);
        out_ready = 1'b1;

`ifdef PIPE_STAGE_PERF_EN
        // 6: stall counter saturates and survives a flush
        do_reset();
        out_ready = 1'b0;
        put(1'b1, 6'h01, 32'hA);
        tick();
        put(1'b0, 6'h0, 32'h0);
        for (int i = 0; i < 20; i++) tick();
        check("p_sat", stall_cnt, 4'd15);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("p_keep", stall_cnt, 4'd15);
        out_ready = 1'b1;
`endif

        // Random traffic
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            in_ctrl   = CW'($urandom);
            in_data   = $urandom;
            flush     = ($urandom_range(0, 40) == 0);
            rst       = ($urandom_range(0, 150) == 0);
            tick();
        end
        rst = 1'b0; flush = 1'b0;
        put(1'b0, 6'h0, 32'h0);
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
